// File: rtl/cla_pkg.sv
// Shared lookahead primitives and geometry helpers for the pipelined CLA adder.
package cla_pkg;

  localparam int unsigned GRP = 4;

  typedef struct packed {
    logic [GRP-1:0] c;  // carry into each bit of the group
    logic           p;  // group propagate
    logic           g;  // group generate
  } grp_t;

  // Flat 4-bit lookahead: every bit carry comes straight from p/g and the group carry-in.
  function automatic grp_t cla_grp(input logic [GRP-1:0] p, input logic [GRP-1:0] g,
                                   input logic c);
    grp_t r;
    r.c[0] = c;
    r.c[1] = g[0] | (p[0] & c);
    r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    r.p    = &p;
    r.g    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return r;
  endfunction

  function automatic bit geom_ok(input int unsigned width, input int unsigned seg);
    return (seg != 0) && (seg % GRP == 0) && (width != 0) && (width % seg == 0);
  endfunction

  // Offset of stage k's forwarded upper operand bits inside the packed triangular store.
  function automatic int unsigned fwd_off(input int unsigned width, input int unsigned seg,
                                          input int unsigned k);
    return k * width - seg * k * (k + 1) / 2;
  endfunction

  // Offset of stage k's partial sum (k+1 slices wide) inside the packed triangular store.
  function automatic int unsigned sum_off(input int unsigned seg, input int unsigned k);
    return seg * k * (k + 1) / 2;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational SEG-bit carry-lookahead slice built from 4-bit lookahead groups.
module cla_slice
  import cla_pkg::*;
#(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  localparam int unsigned NG = SEG / GRP;

  if ((SEG == 0) || (SEG % GRP != 0)) begin : g_bad_seg
    $error("cla_slice: SEG must be a nonzero multiple of 4");
  end

  logic [SEG-1:0] p;
  logic [SEG-1:0] g;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic c;
    grp_t r;
    c  = ci;
    r  = '0;
    s  = '0;
    for (int unsigned j = 0; j < NG; j++) begin
      r = cla_grp(p[j*GRP +: GRP], g[j*GRP +: GRP], c);
      s[j*GRP +: GRP] = p[j*GRP +: GRP] ^ r.c;
      c = r.g | (r.p & c);
    end
    co = c;
  end

endmodule

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder: one SEG-bit slice per stage, carry registered between stages.
module cla_adder_pipe
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             cout,
  output logic             ovf
);
  localparam int unsigned NSTG = WIDTH / SEG;
  localparam int unsigned FTOT = (NSTG > 1) ? fwd_off(WIDTH, SEG, NSTG - 1) : 1;
  localparam int unsigned STOT = sum_off(SEG, NSTG);
  localparam int unsigned SOUT = sum_off(SEG, NSTG - 1);

  if (!geom_ok(WIDTH, SEG)) begin : g_bad_geom
    $error("cla_adder_pipe: WIDTH must be a nonzero multiple of SEG");
  end

  logic            en;
  logic [NSTG-1:0] v_q;
  logic [NSTG-1:0] c_q;
  logic [FTOT-1:0] fa_q;
  logic [FTOT-1:0] fb_q;
  logic [STOT-1:0] s_q;
  logic            ovf_q;

  assign en        = ~v_q[NSTG-1] | out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[NSTG-1];
  assign cout      = c_q[NSTG-1];
  assign sum       = {c_q[NSTG-1], s_q[SOUT +: WIDTH]};
  assign ovf       = ovf_q;

  // Operand and sum stores are triangular: each stage keeps only the bits still ahead of it
  // (operands) or already built (sum), so no register bit is dead.
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int unsigned OW = WIDTH - k * SEG;
    localparam int unsigned SW = (k + 1) * SEG;
    localparam int unsigned SO = sum_off(SEG, k);

    logic [OW-1:0]  op_a;
    logic [OW-1:0]  op_b;
    logic           vin;
    logic           cin_k;
    logic [SEG-1:0] ps;
    logic           pc;
    logic [SW-1:0]  s_next;

    if (k == 0) begin : g_head
      assign op_a   = a;
      assign op_b   = b;
      assign vin    = in_valid;
      assign cin_k  = cin;
      assign s_next = ps;
    end else begin : g_tail
      localparam int unsigned PO  = fwd_off(WIDTH, SEG, k - 1);
      localparam int unsigned PSO = sum_off(SEG, k - 1);
      assign op_a   = fa_q[PO +: OW];
      assign op_b   = fb_q[PO +: OW];
      assign vin    = v_q[k-1];
      assign cin_k  = c_q[k-1];
      assign s_next = {ps, s_q[PSO +: k*SEG]};
    end

    cla_slice #(.SEG(SEG)) u_slice (
      .a  (op_a[SEG-1:0]),
      .b  (op_b[SEG-1:0]),
      .ci (cin_k),
      .s  (ps),
      .co (pc)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q[k]       <= 1'b0;
        c_q[k]       <= 1'b0;
        s_q[SO +: SW] <= '0;
      end else if (en) begin
        v_q[k]       <= vin;
        c_q[k]       <= pc;
        s_q[SO +: SW] <= s_next;
      end
    end

    if (k < NSTG - 1) begin : g_fwd
      localparam int unsigned FO = fwd_off(WIDTH, SEG, k);
      always_ff @(posedge clk) begin
        if (rst) begin
          fa_q[FO +: OW-SEG] <= '0;
          fb_q[FO +: OW-SEG] <= '0;
        end else if (en) begin
          fa_q[FO +: OW-SEG] <= op_a[OW-1:SEG];
          fb_q[FO +: OW-SEG] <= op_b[OW-1:SEG];
        end
      end
    end else begin : g_last
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= (op_a[SEG-1] == op_b[SEG-1]) && (ps[SEG-1] != op_a[SEG-1]);
        end
      end
    end
  end

endmodule
